game_clock_ctrl: RTL and testbench

Countdown game-clock controller for the basketball scoreboard. It owns a gated prescaler that divides clock_in (50 MHz) down to a 1 Hz tick. The tick advances a MM:SS countdown under a start/pause/load FSM. The block also tracks the quarter number, drives the buzzer, and feeds the display/BCD path with minutes, seconds and quarter.

---
 rtl/scoreboard_pkg.sv | 15 +
 rtl/tick_prescaler.sv | 30 +++
 rtl/game_clock_ctrl.sv | 140 ++++++++++++++
 tb/tb_game_clock_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_pkg.sv
// Shared types and constants for the scoreboard game-clock path.
package scoreboard_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_PAUSE     = 3'd2,
        ST_EXPIRED   = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    localparam int SEC_MAX   = 59;
    localparam int DIV_50MHZ = 50_000_000;

endpackage

// File: rtl/tick_prescaler.sv
// Gated, clearable modulo-DIV counter; tick strobes on the wrap cycle while enabled.
module tick_prescaler
    import scoreboard_pkg::*;
#(
    parameter int DIV = DIV_50MHZ
) (
    input  logic clock_in,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_reg;

    assign tick = enable && (cnt_reg == LAST);

    // Holding while disabled keeps a partial second across a pause.
    always_ff @(posedge clock_in) begin
        if (reset || clear) begin
            cnt_reg <= '0;
        end else if (enable) begin
            cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/game_clock_ctrl.sv
// Countdown game clock: MM:SS timer, quarter tracking and horn, driven by a 1 Hz prescaler.
module game_clock_ctrl
    import scoreboard_pkg::*;
#(
    parameter int DIV          = DIV_50MHZ,
    parameter int PRESET_MIN   = 10,
    parameter int PRESET_SEC   = 0,
    parameter int BUZZ_CYCLES  = 100_000_000,
    parameter int NUM_QUARTERS = 4
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       start_pause,
    input  logic       load,
    output logic [3:0] minutes,
    output logic [5:0] seconds,
    output logic [2:0] quarter,
    output logic       running,
    output logic       expired,
    output logic       game_over,
    output logic       buzzer,
    output logic       tick
);

    localparam int BW = $clog2(BUZZ_CYCLES + 1);

    state_t          state_reg;
    logic [3:0]      min_reg;
    logic [5:0]      sec_reg;
    logic [2:0]      quarter_reg;
    logic            tick_reg;
    logic            buzzer_reg;
    logic [BW-1:0]   buzz_cnt_reg;

    logic [3:0]      dec_min;
    logic [5:0]      dec_sec;
    logic            dec_zero;
    logic            pre_tick;
    logic            load_act;
    logic            expire_now;

    always_comb begin
        dec_min = min_reg;
        dec_sec = sec_reg;
        if (sec_reg != 6'd0) begin
            dec_sec = sec_reg - 6'd1;
        end else if (min_reg != 4'd0) begin
            dec_min = min_reg - 4'd1;
            dec_sec = 6'(SEC_MAX);
        end
        dec_zero = (dec_min == 4'd0) && (dec_sec == 6'd0);
    end

    assign load_act   = load && (state_reg != ST_GAME_OVER);
    assign expire_now = (state_reg == ST_RUN) && !load && pre_tick && dec_zero;

    tick_prescaler #(.DIV(DIV)) u_prescaler (
        .clock_in (clock_in),
        .reset    (reset),
        .enable   (state_reg == ST_RUN),
        .clear    (load_act || expire_now),
        .tick     (pre_tick)
    );

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            min_reg      <= 4'(PRESET_MIN);
            sec_reg      <= 6'(PRESET_SEC);
            quarter_reg  <= 3'd1;
            tick_reg     <= 1'b0;
            buzzer_reg   <= 1'b0;
            buzz_cnt_reg <= '0;
        end else begin
            tick_reg <= 1'b0;
            // Horn runs to completion regardless of loads; expiry reloads it below.
            if (buzz_cnt_reg != '0) begin
                buzz_cnt_reg <= buzz_cnt_reg - 1'b1;
                buzzer_reg   <= (buzz_cnt_reg > BW'(1));
            end

            case (state_reg)
                ST_IDLE, ST_PAUSE: begin
                    if (load) begin
                        min_reg   <= 4'(PRESET_MIN);
                        sec_reg   <= 6'(PRESET_SEC);
                        state_reg <= ST_IDLE;
                    end else if (start_pause) begin
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (load) begin
                        min_reg   <= 4'(PRESET_MIN);
                        sec_reg   <= 6'(PRESET_SEC);
                        state_reg <= ST_IDLE;
                    end else if (pre_tick) begin
                        min_reg  <= dec_min;
                        sec_reg  <= dec_sec;
                        tick_reg <= 1'b1;
                        if (dec_zero) begin
                            state_reg    <= ST_EXPIRED;
                            buzz_cnt_reg <= BW'(BUZZ_CYCLES);
                            buzzer_reg   <= 1'b1;
                        end else if (start_pause) begin
                            state_reg <= ST_PAUSE;
                        end
                    end else if (start_pause) begin
                        state_reg <= ST_PAUSE;
                    end
                end
                ST_EXPIRED: begin
                    if (load) begin
                        if (quarter_reg < 3'(NUM_QUARTERS)) begin
                            quarter_reg <= quarter_reg + 3'd1;
                            min_reg     <= 4'(PRESET_MIN);
                            sec_reg     <= 6'(PRESET_SEC);
                            state_reg   <= ST_IDLE;
                        end else begin
                            state_reg <= ST_GAME_OVER;
                        end
                    end
                end
                default: begin
                    state_reg <= state_reg;
                end
            endcase
        end
    end

    assign minutes   = min_reg;
    assign seconds   = sec_reg;
    assign quarter   = quarter_reg;
    assign running   = (state_reg == ST_RUN);
    assign expired   = (state_reg == ST_EXPIRED);
    assign game_over = (state_reg == ST_GAME_OVER);
    assign buzzer    = buzzer_reg;
    assign tick      = tick_reg;

endmodule

// File: tb/tb_game_clock_ctrl.sv
// Directed bench with a cycle-level reference model feeding an expected-output queue.
module tb_game_clock_ctrl;

    localparam int DIV = 4;
    localparam int PM  = 0;
    localparam int PS  = 3;
    localparam int BC  = 3;
    localparam int NQ  = 2;

    logic       clock_in = 1'b0;
    logic       reset = 1'b0;
    logic       start_pause = 1'b0;
    logic       load = 1'b0;
    logic [3:0] minutes, minutes_b;
    logic [5:0] seconds, seconds_b;
    logic [2:0] quarter, quarter_b;
    logic       running, expired, game_over, buzzer, tick;
    logic       running_b, expired_b, game_over_b, buzzer_b, tick_b;

    always #5 clock_in = ~clock_in;

    game_clock_ctrl #(.DIV(DIV), .PRESET_MIN(PM), .PRESET_SEC(PS),
                      .BUZZ_CYCLES(BC), .NUM_QUARTERS(NQ)) dut (
        .clock_in(clock_in), .reset(reset), .start_pause(start_pause), .load(load),
        .minutes(minutes), .seconds(seconds), .quarter(quarter), .running(running),
        .expired(expired), .game_over(game_over), .buzzer(buzzer), .tick(tick)
    );

    // Second instance exercises the minute-borrow preset 1:00.
    game_clock_ctrl #(.DIV(DIV), .PRESET_MIN(1), .PRESET_SEC(0),
                      .BUZZ_CYCLES(BC), .NUM_QUARTERS(NQ)) dut_b (
        .clock_in(clock_in), .reset(reset), .start_pause(start_pause), .load(load),
        .minutes(minutes_b), .seconds(seconds_b), .quarter(quarter_b), .running(running_b),
        .expired(expired_b), .game_over(game_over_b), .buzzer(buzzer_b), .tick(tick_b)
    );

    int n_pass = 0;
    int n_total = 0;
    logic [16:0] exp_q[$];

    // Model state: 0 idle, 1 run, 2 pause, 3 expired, 4 game over.
    int m_st, m_min, m_sec, m_q, m_pre, m_buzz, m_tk;

    function automatic logic [16:0] pack(input int mn, input int sc, input int q,
                                         input bit r, input bit e, input bit g,
                                         input bit b, input bit t);
        return {4'(mn), 6'(sc), 3'(q), r, e, g, b, t};
    endfunction

    function automatic logic [16:0] dut_vec();
        return {minutes, seconds, quarter, running, expired, game_over, buzzer, tick};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_edge(input bit r, input bit s, input bit l);
        bit wrap;
        int total;
        if (r) begin
            m_st = 0; m_min = PM; m_sec = PS; m_q = 1; m_pre = 0; m_buzz = 0; m_tk = 0;
            return;
        end
        m_tk = 0;
        if (m_buzz > 0) m_buzz--;
        wrap = (m_st == 1) && (m_pre == DIV - 1);
        if (m_st == 1) m_pre = wrap ? 0 : m_pre + 1;
        if (m_st == 4) begin
        end else if (l) begin
            m_pre = 0;
            if (m_st == 3) begin
                if (m_q < NQ) begin
                    m_q++; m_min = PM; m_sec = PS; m_st = 0;
                end else begin
                    m_st = 4;
                end
            end else begin
                m_min = PM; m_sec = PS; m_st = 0;
            end
        end else if (wrap) begin
            total = m_min * 60 + m_sec - 1;
            m_min = total / 60;
            m_sec = total % 60;
            m_tk = 1;
            if (total == 0) begin
                m_st = 3; m_buzz = BC; m_pre = 0;
            end else if (s) begin
                m_st = 2;
            end
        end else if (s) begin
            if (m_st == 0 || m_st == 2) m_st = 1;
            else if (m_st == 1) m_st = 2;
        end
    endtask

    task automatic step(input bit r = 0, input bit s = 0, input bit l = 0);
        logic [16:0] e;
        reset = r; start_pause = s; load = l;
        model_edge(r, s, l);
        exp_q.push_back(pack(m_min, m_sec, m_q, m_st == 1, m_st == 3, m_st == 4,
                             m_buzz > 0, m_tk == 1));
        @(posedge clock_in);
        #1;
        reset = 0; start_pause = 0; load = 0;
        e = exp_q.pop_front();
        $display("t=%0t rst=%0b sp=%0b ld=%0b time=%0d:%02d q=%0d run=%0b exp=%0b go=%0b bz=%0b tk=%0b",
                 $time, r, s, l, minutes, seconds, quarter, running, expired, game_over, buzzer, tick);
        chk("cycle", 32'(dut_vec()), 32'(e));
    endtask

    task automatic run_until_tick(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (tick) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int bcnt;
        bit s;

        // Reset state
        step(1); step(1);
        chk("reset_vec", 32'(dut_vec()), 32'(pack(0, 3, 1, 0, 0, 0, 0, 0)));

        // Run to expiry, tick every DIV cycles, horn length
        step(0, 1, 0);
        chk("run_entry", 32'(running), 32'd1);
        run_until_tick(n);
        chk("tick1_latency", 32'(n), 32'd4);
        chk("tick1_sec", 32'(seconds), 32'd2);
        chk("borrow_b", 32'({minutes_b, seconds_b, tick_b}), 32'({4'd0, 6'd59, 1'b1}));
        run_until_tick(n);
        chk("tick2_latency", 32'(n), 32'd4);
        run_until_tick(n);
        chk("tick3_latency", 32'(n), 32'd4);
        chk("expiry_flags", 32'({seconds, expired, running, buzzer}), 32'({6'd0, 3'b101}));
        bcnt = buzzer ? 1 : 0;
        repeat (6) begin
            step();
            bcnt += buzzer ? 1 : 0;
        end
        chk("buzz_len", 32'(bcnt), 32'd3);

        // Next quarter
        step(0, 0, 1);
        chk("quarter_adv", 32'(dut_vec()), 32'(pack(0, 3, 2, 0, 0, 0, 0, 0)));

        // Pause preserves a partial second
        step(0, 1, 0);
        run_until_tick(n);
        chk("q2_tick1", 32'(n), 32'd4);
        step();
        step(0, 1, 0);
        chk("paused", 32'({running, seconds}), 32'({1'b0, 6'd2}));
        repeat (10) step();
        chk("pause_hold", 32'({running, seconds}), 32'({1'b0, 6'd2}));
        step(0, 1, 0);
        run_until_tick(n);
        chk("resume_latency", 32'(n), 32'd2);
        chk("resume_sec", 32'(seconds), 32'd1);

        // Load beats start_pause
        step(0, 1, 1);
        chk("load_wins", 32'(dut_vec()), 32'(pack(0, 3, 2, 0, 0, 0, 0, 0)));

        // Final quarter expiry leads to game over
        step(0, 1, 0);
        for (int i = 0; i < 3 && !expired; i++) run_until_tick(n);
        chk("q2_expired", 32'(expired), 32'd1);
        step(0, 0, 1);
        chk("game_over", 32'({game_over, minutes, seconds}), 32'({1'b1, 4'd0, 6'd0}));
        step(0, 1, 0); step(0, 0, 1); step(0, 1, 1); step();
        chk("game_over_sticky", 32'({game_over, running, minutes, seconds, quarter}),
            32'({1'b1, 1'b0, 4'd0, 6'd0, 3'd2}));

        // Reset mid-count
        step(1);
        step(0, 1, 0);
        run_until_tick(n);
        step(); step();
        chk("pre_reset_sec", 32'(seconds), 32'd2);
        step(1);
        chk("reset_mid", 32'(dut_vec()), 32'(pack(0, 3, 1, 0, 0, 0, 0, 0)));

        // start_pause on a non-final tick, then on the final tick
        step(0, 1, 0);
        repeat (3) step();
        step(0, 1, 0);
        chk("sp_on_tick", 32'({seconds, running, tick}), 32'({6'd2, 1'b0, 1'b1}));
        step(0, 1, 0);
        n = 0;
        for (int i = 0; i < 20 && !expired; i++) begin
            s = (m_st == 1) && (m_pre == DIV - 1) && (m_min == 0) && (m_sec == 1);
            if (s) n++;
            step(0, s, 0);
        end
        chk("sp_on_final", 32'({expired, running, n[0]}), 32'({1'b1, 1'b0, 1'b1}));

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
